// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg
// Shared definitions for the SPI-flash responder: supported opcodes,
// the transaction state encoding and a helper that selects one byte
// of the 3-byte JEDEC identifier.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ID,
    STATUS,
    IGNORE
  } state_e;

  // Byte idx of the identifier, most significant byte first. Any index
  // past the third byte reads as zero, which is what the device shifts
  // out once the identifier is exhausted.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    return id[23:16];
      2'd1:    return id[15:8];
      2'd2:    return id[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// spi_pin_sync
// Brings the three SPI pins into the clk domain through two-flop
// synchronizers and derives single-cycle sclk edge pulses from a third
// flop on the synchronized clock.
// Ports:
//   clk        system clock
//   sclk       raw SPI clock pin
//   cs_n       raw chip-select pin
//   mosi       raw master-out pin
//   cs_n_sync  synchronized chip select
//   mosi_sync  synchronized MOSI, aligned with the sclk edge pulses
//   sclk_rise  one-cycle pulse per synchronized rising sclk edge
//   sclk_fall  one-cycle pulse per synchronized falling sclk edge
module spi_pin_sync (
  input  logic clk,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic cs_n_sync,
  output logic mosi_sync,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [2:0] pins;
  logic [2:0] synced;
  logic       sclk_d_reg;

  assign pins = {mosi, cs_n, sclk};

  // The synchronizers carry no reset on purpose: they keep tracking the
  // pins while reset is held, so the FSM sees the true cs_n level the
  // moment reset releases and never mistakes a stale reset value for a
  // fresh chip-select edge.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
        meta_reg <= pins[gi];
        sync_reg <= meta_reg;
      end
      assign synced[gi] = sync_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    sclk_d_reg <= synced[0];
  end

  assign sclk_rise = synced[0] & ~sclk_d_reg;
  assign sclk_fall = ~synced[0] & sclk_d_reg;
  assign cs_n_sync = synced[1];
  assign mosi_sync = synced[2];

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
// Mode-0 single-bit SPI flash model that answers READ (0x03),
// READ-JEDEC-ID (0x9F) and READ-STATUS (0x05) from an internal byte
// array. The SPI pins are oversampled on clk (ratio at least 8).
// Ports:
//   clk, reset_n   system clock, synchronous active-low reset
//   i_sclk/i_cs_n/i_mosi  SPI pins from the master (asynchronous)
//   o_miso         SPI data back to the master
//   i_load_we/i_load_addr/i_load_data  side-band array preload port
//   o_busy         high while a transaction is in progress
//   o_xfer_count   completed transactions, wraps at 2^16
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          MEM_BYTES = 65536,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_sclk,
  input  logic                         i_cs_n,
  input  logic                         i_mosi,
  output logic                         o_miso,
  input  logic                         i_load_we,
  input  logic [$clog2(MEM_BYTES)-1:0] i_load_addr,
  input  logic [7:0]                   i_load_data,
  output logic                         o_busy,
  output logic [15:0]                  o_xfer_count
);

  localparam int AW = $clog2(MEM_BYTES);
  // Only the address bits that index the array are kept; the shifter
  // also has to hold seven command bits, hence the floor of 7.
  localparam int SHW = (AW - 1 > 7) ? AW - 1 : 7;
  localparam logic [AW-1:0] ADDR_ONE = 1;

  logic cs_n_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;

  spi_pin_sync u_sync (
    .clk       (clk),
    .sclk      (i_sclk),
    .cs_n      (i_cs_n),
    .mosi      (i_mosi),
    .cs_n_sync (cs_n_s),
    .mosi_sync (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  state_e          state_reg,     state_next;
  logic [4:0]      bit_cnt_reg,   bit_cnt_next;
  logic [1:0]      byte_cnt_reg,  byte_cnt_next;
  logic [SHW-1:0]  shift_reg,     shift_next;
  logic [AW-1:0]   addr_reg,      addr_next;
  logic [7:0]      tx_reg,        tx_next;
  logic            tx_load_reg,   tx_load_next;
  logic            src_mem_reg,   src_mem_next;
  logic [7:0]      next_byte_reg, next_byte_next;
  logic            miso_reg,      miso_next;
  logic [15:0]     count_reg,     count_next;
  logic            armed_reg,     armed_next;
  logic            busy_reg,      busy_next;

  logic            fetch_en;
  logic [AW-1:0]   fetch_addr;
  logic [7:0]      rd_data_reg;
  logic [7:0]      load_byte;
  logic [7:0]      cmd_byte;
  logic [AW-1:0]   wire_addr;

  logic [7:0] mem [MEM_BYTES];

  // Byte array: preload writes and FSM fetches share one port pair.
  // A fetch colliding with a load to the same address sees the old byte.
  always_ff @(posedge clk) begin
    if (i_load_we) begin
      mem[i_load_addr] <= i_load_data;
    end
    if (fetch_en) begin
      rd_data_reg <= mem[fetch_addr];
    end
  end

  // Command and address values as they stand including the bit arriving
  // on the current rising edge.
  assign cmd_byte  = {shift_reg[6:0], mosi_s};
  assign wire_addr = {shift_reg[AW-2:0], mosi_s};

  // The next byte to shift out comes either from the array read port or
  // from a constant staged by the ID/STATUS paths.
  assign load_byte = src_mem_reg ? rd_data_reg : next_byte_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      byte_cnt_reg  <= '0;
      shift_reg     <= '0;
      addr_reg      <= '0;
      tx_reg        <= '0;
      tx_load_reg   <= 1'b0;
      src_mem_reg   <= 1'b0;
      next_byte_reg <= '0;
      miso_reg      <= 1'b0;
      count_reg     <= '0;
      armed_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
      shift_reg     <= shift_next;
      addr_reg      <= addr_next;
      tx_reg        <= tx_next;
      tx_load_reg   <= tx_load_next;
      src_mem_reg   <= src_mem_next;
      next_byte_reg <= next_byte_next;
      miso_reg      <= miso_next;
      count_reg     <= count_next;
      armed_reg     <= armed_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    byte_cnt_next  = byte_cnt_reg;
    shift_next     = shift_reg;
    addr_next      = addr_reg;
    tx_next        = tx_reg;
    tx_load_next   = tx_load_reg;
    src_mem_next   = src_mem_reg;
    next_byte_next = next_byte_reg;
    miso_next      = miso_reg;
    count_next     = count_reg;
    fetch_en       = 1'b0;
    fetch_addr     = addr_reg;

    // armed only sets once cs_n has been seen high after reset, so a
    // master that was already selected when reset hit is ignored until
    // it deselects and selects again.
    armed_next = armed_reg | cs_n_s;
    busy_next  = ~cs_n_s & armed_reg;

    if (cs_n_s) begin
      if (state_reg != IDLE) begin
        count_next = count_reg + 16'd1;
      end
      state_next    = IDLE;
      bit_cnt_next  = '0;
      byte_cnt_next = '0;
      tx_load_next  = 1'b0;
      miso_next     = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (armed_reg) begin
            state_next   = CMD;
            bit_cnt_next = '0;
            miso_next    = 1'b0;
          end
        end

        CMD: begin
          if (sclk_rise) begin
            shift_next = {shift_reg[SHW-2:0], mosi_s};
            if (bit_cnt_reg == 5'd7) begin
              bit_cnt_next = '0;
              case (cmd_byte)
                CMD_READ: state_next = ADDR;
                CMD_RDID: begin
                  state_next     = ID;
                  next_byte_next = id_byte(JEDEC_ID, 2'd0);
                  byte_cnt_next  = 2'd1;
                  tx_load_next   = 1'b1;
                  src_mem_next   = 1'b0;
                end
                CMD_RDSR: begin
                  state_next     = STATUS;
                  next_byte_next = 8'h00;
                  tx_load_next   = 1'b1;
                  src_mem_next   = 1'b0;
                end
                default:  state_next = IGNORE;
              endcase
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
            end
          end
        end

        ADDR: begin
          if (sclk_rise) begin
            shift_next = {shift_reg[SHW-2:0], mosi_s};
            if (bit_cnt_reg == 5'd23) begin
              fetch_en     = 1'b1;
              fetch_addr   = wire_addr;
              addr_next    = wire_addr;
              tx_load_next = 1'b1;
              src_mem_next = 1'b1;
              bit_cnt_next = '0;
              state_next   = DATA;
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
            end
          end
        end

        DATA, ID, STATUS: begin
          if (sclk_rise) begin
            if (bit_cnt_reg == 5'd7) begin
              bit_cnt_next = '0;
              tx_load_next = 1'b1;
              if (state_reg == DATA) begin
                addr_next  = addr_reg + ADDR_ONE;
                fetch_en   = 1'b1;
                fetch_addr = addr_reg + ADDR_ONE;
              end else if (state_reg == ID) begin
                next_byte_next = id_byte(JEDEC_ID, byte_cnt_reg);
                if (byte_cnt_reg != 2'd3) begin
                  byte_cnt_next = byte_cnt_reg + 2'd1;
                end
              end else begin
                next_byte_next = 8'h00;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
            end
          end
          if (sclk_fall) begin
            // The first fall of each byte takes the staged byte; the
            // rest walk the shift register MSB-first.
            if (tx_load_reg) begin
              miso_next    = load_byte[7];
              tx_next      = {load_byte[6:0], 1'b0};
              tx_load_next = 1'b0;
            end else begin
              miso_next = tx_reg[7];
              tx_next   = {tx_reg[6:0], 1'b0};
            end
          end
        end

        default: begin
          // IGNORE: MOSI is dropped and MISO stays low.
          miso_next = 1'b0;
        end
      endcase
    end
  end

  assign o_miso       = miso_reg;
  assign o_busy       = busy_reg;
  assign o_xfer_count = count_reg;

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;

  localparam int MEM_BYTES = 65536;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        load_we;
  logic [15:0] load_addr;
  logic [7:0]  load_data;
  logic        busy;
  logic [15:0] xfer_count;

  int pass_count  = 0;
  int check_count = 0;
  int half_cycles = 4;
  int exp_count   = 0;

  always #5 clk = ~clk;

  spi_flash_responder #(
    .MEM_BYTES (MEM_BYTES),
    .JEDEC_ID  (24'hEF4016)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_sclk       (sclk),
    .i_cs_n       (cs_n),
    .i_mosi       (mosi),
    .o_miso       (miso),
    .i_load_we    (load_we),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .o_busy       (busy),
    .o_xfer_count (xfer_count)
  );

  typedef struct {
    logic [7:0]  opcode;
    logic [23:0] addr;
    bit          has_addr;
    int          nbytes;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0 master: MOSI changes while sclk is low, MISO sampled at rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_neg(half_cycles);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      wait_neg(half_cycles);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_release();
    wait_neg(half_cycles);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_neg(8);
  endtask

  task automatic spi_txn(input string name, input logic [7:0] op, input logic [23:0] addr,
                         input bit has_addr, input int nbytes, output logic [39:0] rx);
    logic [7:0] b;
    rx = '0;
    cs_n = 1'b0;
    wait_neg(half_cycles);
    check({name, " busy_active"}, 40'(busy), 40'd1);
    spi_bits(op, 8, b);
    if (has_addr) begin
      spi_bits(addr[23:16], 8, b);
      spi_bits(addr[15:8], 8, b);
      spi_bits(addr[7:0], 8, b);
    end
    for (int i = 0; i < nbytes; i++) begin
      spi_bits(8'h00, 8, b);
      rx = {rx[31:0], b};
    end
    cs_release();
    exp_count++;
    check({name, " xfer_count"}, 40'(xfer_count), 40'(exp_count & 32'hFFFF));
    check({name, " busy_idle"}, 40'(busy), 40'd0);
    $display("txn %s ratio %0d: op=%h rx=%h count=%0d", name, 2 * half_cycles, op, rx, xfer_count);
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_we   = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] rx;
    logic [7:0]  b;

    vecs[0] = '{8'h03, 24'h000010, 1'b1, 4, 40'h00A1B2C3D4};
    vecs[1] = '{8'h03, 24'h00FFFF, 1'b1, 2, 40'h0000005A77};
    vecs[2] = '{8'h9F, 24'h000000, 1'b0, 5, 40'hEF40160000};
    vecs[3] = '{8'h05, 24'h000000, 1'b0, 2, 40'h0000000000};
    vecs[4] = '{8'hAB, 24'h000000, 1'b0, 2, 40'h0000000000};
    vecs[5] = '{8'h03, 24'h000020, 1'b1, 1, 40'h000000003C};
    vecs[6] = '{8'h03, 24'hFF0010, 1'b1, 1, 40'h00000000A1};

    reset_n   = 1'b0;
    sclk      = 1'b0;
    cs_n      = 1'b1;
    mosi      = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    wait_neg(3);

    // Preload while reset is held.
    load(16'h0010, 8'hA1);
    load(16'h0011, 8'hB2);
    load(16'h0012, 8'hC3);
    load(16'h0013, 8'hD4);
    load(16'hFFFF, 8'h5A);
    load(16'h0000, 8'h77);
    load(16'h0020, 8'h3C);

    for (int r = 0; r < 2; r++) begin
      half_cycles = (r == 0) ? 4 : 8;
      reset_n = 1'b0;
      wait_neg(4);
      reset_n = 1'b1;
      wait_neg(4);
      exp_count = 0;
      check("reset miso", 40'(miso), 40'd0);
      check("reset busy", 40'(busy), 40'd0);
      check("reset xfer_count", 40'(xfer_count), 40'd0);

      for (int i = 0; i < 7; i++) begin
        spi_txn($sformatf("vec%0d", i), vecs[i].opcode, vecs[i].addr,
                vecs[i].has_addr, vecs[i].nbytes, rx);
        check($sformatf("vec%0d data", i), rx, vecs[i].exp);
      end

      // Abort after 12 address bits, then a fresh READ.
      cs_n = 1'b0;
      wait_neg(half_cycles);
      spi_bits(8'h03, 8, b);
      spi_bits(8'h00, 8, b);
      spi_bits(8'h00, 4, b);
      cs_release();
      exp_count++;
      check("abort xfer_count", 40'(xfer_count), 40'(exp_count));
      $display("txn abort ratio %0d: count=%0d", 2 * half_cycles, xfer_count);
      spi_txn("after_abort", 8'h03, 24'h000010, 1'b1, 1, rx);
      check("after_abort data", rx, 40'hA1);

      // Reset in the middle of DATA with the master still selected.
      cs_n = 1'b0;
      wait_neg(half_cycles);
      spi_bits(8'h03, 8, b);
      spi_bits(8'h00, 8, b);
      spi_bits(8'h00, 8, b);
      spi_bits(8'h10, 8, b);
      spi_bits(8'h00, 2, b);
      check("middata first bits", 40'(b), 40'h2);
      wait_neg(half_cycles);
      check("middata miso bit5", 40'(miso), 40'd1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_count = 0;
      check("midreset miso", 40'(miso), 40'd0);
      check("midreset busy", 40'(busy), 40'd0);
      check("midreset xfer_count", 40'(xfer_count), 40'd0);
      spi_bits(8'h00, 8, b);
      check("held cs ignored miso", 40'(b), 40'd0);
      check("held cs ignored busy", 40'(busy), 40'd0);
      cs_release();
      check("held cs no count", 40'(xfer_count), 40'd0);
      $display("txn midreset ratio %0d: count=%0d", 2 * half_cycles, xfer_count);
      spi_txn("after_reset", 8'h03, 24'h000010, 1'b1, 1, rx);
      check("after_reset data", rx, 40'hA1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
